// File: rtl/serial_word_deserializer.sv
// Framed serial-to-parallel word assembler with registered output word and one-cycle strobes.
// Optional trailing even-parity bit and parity_err output when DESER_PARITY_EN is defined.
module serial_word_deserializer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             busy,
    output logic             frame_err
`ifdef DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_next;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    logic start_bit, data_bit, last_data, load_word, abort_frame, par_fail;
    logic [WIDTH-1:0] word_src;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base, input logic b);
        if (MSB_FIRST)
            return {base[WIDTH-2:0], b};
        else
            return {b, base[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        start_bit   = sin_valid && frame_start;
        data_bit    = sin_valid && !frame_start;
        last_data   = (state == SHIFT) && data_bit && (cnt == CW'(WIDTH - 1));
        abort_frame = start_bit && (state != IDLE);
        load_word   = 1'b0;
        par_fail    = 1'b0;
        word_src    = shift_in(sreg, sin);
        state_next  = state;
        if (start_bit) begin
            state_next = SHIFT;
        end else begin
            case (state)
                SHIFT: begin
                    if (last_data) begin
`ifdef DESER_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = IDLE;
                        load_word  = 1'b1;
`endif
                    end
                end
`ifdef DESER_PARITY_EN
                PARITY: begin
                    // Even parity: the parity bit equals the XOR of all data bits.
                    word_src = sreg;
                    if (data_bit) begin
                        state_next = IDLE;
                        load_word  = (^sreg) == sin;
                        par_fail   = (^sreg) != sin;
                    end
                end
`endif
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            word_valid <= load_word;
            frame_err  <= abort_frame;
`ifdef DESER_PARITY_EN
            parity_err <= par_fail;
`endif
            if (start_bit) begin
                sreg <= shift_in('0, sin);
                cnt  <= CW'(1);
            end else if (data_bit && (state == SHIFT)) begin
                sreg <= shift_in(sreg, sin);
                cnt  <= last_data ? '0 : cnt + CW'(1);
            end
            if (load_word)
                word <= word_src;
        end
    end

`ifndef DESER_PARITY_EN
    logic unused_par;
    assign unused_par = par_fail;
`endif

endmodule
